// File: rtl/join_pkg.sv
`default_nettype none
// ============================================================================
// Module   : join_pkg
// Brief    : Shared FSM state type and legal parameter bounds for join_n.
// Revision : 1.0
// ============================================================================
package join_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_RTZ  = 2'd3
  } join_state_e;

  localparam int c_num_in_min = 2;
  localparam int c_num_in_max = 16;
  localparam int c_data_w_min = 1;
  localparam int c_data_w_max = 64;
  localparam int c_cnt_w_min  = 1;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/join_slot.sv
`default_nettype none
// ============================================================================
// Module   : join_slot
// Brief    : One input channel of the join: arrival flag plus captured payload.
// Revision : 1.0
// ============================================================================
module join_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_open,
  input  logic              i_clear,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_arr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_arr;
  logic [DATA_W-1:0] r_data;

  // Payload is latched once on arrival and held until the join completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_arr  <= 1'b0;
      r_data <= '0;
    end else if (i_clear) begin
      r_arr  <= 1'b0;
    end else if (i_open && i_req && !r_arr) begin
      r_arr  <= 1'b1;
      r_data <= i_data;
    end
  end

  assign o_arr  = r_arr;
  // A channel arriving on the completing edge contributes its live payload.
  assign o_data = r_arr ? r_data : i_data;

endmodule
`default_nettype wire

// File: rtl/join_n.sv
`default_nettype none
// ============================================================================
// Module   : join_n
// Brief    : N-way four-phase handshake join with payload capture and checks.
// Revision : 1.0
// ============================================================================
module join_n
  import join_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_IN-1:0]        req_in_i,
  input  logic [NUM_IN*DATA_W-1:0] data_in_i,
  output logic [NUM_IN-1:0]        ack_in_o,
  output logic                     req_out_o,
  output logic [NUM_IN*DATA_W-1:0] data_out_o,
  input  logic                     ack_out_i,
  output logic                     err_o,
  output logic [CNT_W-1:0]         txn_cnt_o
);

  if (!in_range(NUM_IN, c_num_in_min, c_num_in_max)) begin : g_bad_num_in
    $error("join_n: NUM_IN out of legal range");
  end
  if (!in_range(DATA_W, c_data_w_min, c_data_w_max)) begin : g_bad_data_w
    $error("join_n: DATA_W out of legal range");
  end
  if (CNT_W < c_cnt_w_min) begin : g_bad_cnt_w
    $error("join_n: CNT_W out of legal range");
  end

  join_state_e                r_state,    w_state_nxt;
  logic                       r_req_out,  w_req_out_nxt;
  logic [NUM_IN-1:0]          r_ack_in,   w_ack_in_nxt;
  logic [NUM_IN*DATA_W-1:0]   r_data_out, w_data_out_nxt;
  logic                       r_err,      w_err_nxt;
  logic [CNT_W-1:0]           r_cnt,      w_cnt_nxt;

  logic [NUM_IN-1:0]          w_arr;
  logic [NUM_IN*DATA_W-1:0]   w_join_data;
  logic                       w_open;
  logic                       w_clear;

  assign w_open  = (r_state == ST_IDLE);
  assign w_clear = (r_state == ST_RTZ) && !ack_out_i;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_slot
    join_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_open  (w_open),
      .i_clear (w_clear),
      .i_req   (req_in_i[k]),
      .i_data  (data_in_i[k*DATA_W +: DATA_W]),
      .o_arr   (w_arr[k]),
      .o_data  (w_join_data[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_req_out  <= 1'b0;
      r_ack_in   <= '0;
      r_data_out <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_out  <= w_req_out_nxt;
      r_ack_in   <= w_ack_in_nxt;
      r_data_out <= w_data_out_nxt;
      r_err      <= w_err_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_out_nxt  = r_req_out;
    w_ack_in_nxt   = r_ack_in;
    w_data_out_nxt = r_data_out;
    w_err_nxt      = r_err;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      ST_IDLE: begin
        // Withdrawn request or a stray downstream ack are both violations.
        if ((|(w_arr & ~req_in_i)) || ack_out_i) begin
          w_err_nxt = 1'b1;
        end
        if (&(w_arr | req_in_i)) begin
          w_state_nxt    = ST_REQ;
          w_req_out_nxt  = 1'b1;
          w_data_out_nxt = w_join_data;
        end
      end
      ST_REQ: begin
        if (!(&req_in_i)) begin
          w_err_nxt = 1'b1;
        end
        if (ack_out_i) begin
          w_state_nxt  = ST_ACK;
          w_ack_in_nxt = '1;
        end
      end
      ST_ACK: begin
        if (req_in_i == '0) begin
          w_state_nxt   = ST_RTZ;
          w_req_out_nxt = 1'b0;
        end
      end
      ST_RTZ: begin
        if (!ack_out_i) begin
          w_state_nxt  = ST_IDLE;
          w_ack_in_nxt = '0;
          w_cnt_nxt    = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_out_o  = r_req_out;
  assign ack_in_o   = r_ack_in;
  assign data_out_o = r_data_out;
  assign err_o      = r_err;
  assign txn_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_join_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_join_n
// Brief    : Self-checking bench for join_n against a protocol-level model.
// Revision : 1.0
// ============================================================================
module tb_join_n;

  localparam int NUM_IN = 3;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int W      = NUM_IN * DATA_W;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NUM_IN-1:0] req_in  = '0;
  logic [W-1:0]      data_in = '0;
  logic              ack_out = 1'b0;
  logic [NUM_IN-1:0] ack_in;
  logic              req_out;
  logic [W-1:0]      data_out;
  logic              err;
  logic [CNT_W-1:0]  cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  join_n #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_in_i   (req_in),
    .data_in_i  (data_in),
    .ack_in_o   (ack_in),
    .req_out_o  (req_out),
    .data_out_o (data_out),
    .ack_out_i  (ack_out),
    .err_o      (err),
    .txn_cnt_o  (cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol-level reference: phase 0 collecting, 1 awaiting downstream ack,
  // 2 awaiting release of all inputs, 3 awaiting downstream ack drop.
  int                m_phase = 0;
  bit [NUM_IN-1:0]   m_arr   = '0;
  bit [DATA_W-1:0]   m_cap [NUM_IN];
  bit                m_req   = 1'b0;
  bit [NUM_IN-1:0]   m_ack   = '0;
  bit [W-1:0]        m_dout  = '0;
  bit                m_err   = 1'b0;
  int                m_cnt   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_arr = '0; m_req = 1'b0; m_ack = '0;
      m_dout = '0; m_err = 1'b0; m_cnt = 0;
    end else begin
      case (m_phase)
        0: begin
          for (int k = 0; k < NUM_IN; k++) begin
            if (m_arr[k] && !req_in[k]) m_err = 1'b1;
            else if (!m_arr[k] && req_in[k]) begin
              m_arr[k] = 1'b1;
              m_cap[k] = data_in[k*DATA_W +: DATA_W];
            end
          end
          if (ack_out) m_err = 1'b1;
          if (m_arr == {NUM_IN{1'b1}}) begin
            m_phase = 1;
            m_req   = 1'b1;
            for (int k = 0; k < NUM_IN; k++) m_dout[k*DATA_W +: DATA_W] = m_cap[k];
          end
        end
        1: begin
          if (req_in != {NUM_IN{1'b1}}) m_err = 1'b1;
          if (ack_out) begin m_phase = 2; m_ack = '1; end
        end
        2: if (req_in == '0) begin m_phase = 3; m_req = 1'b0; end
        default: if (!ack_out) begin
          m_phase = 0; m_ack = '0; m_arr = '0;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cyc_req_out", req_out, m_req);
    chk("cyc_ack_in", ack_in, m_ack);
    chk("cyc_data_out", data_out, m_dout);
    chk("cyc_err", err, m_err);
    chk("cyc_txn_cnt", cnt, m_cnt[CNT_W-1:0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [W-1:0] d);
    req_in = '1; data_in = d; tick();
    ack_out = 1'b1; tick();
    req_in = '0; tick();
    ack_out = 1'b0; tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_out", req_out, 0);
    chk("rst_ack_in", ack_in, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);

    // Staggered arrival; channel 0 payload changes after capture.
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin req_in[0] = 1'b1; data_in[7:0]   = 8'h11; end
      if (c == 5) begin req_in[1] = 1'b1; data_in[15:8]  = 8'h22; end
      if (c == 6) data_in[7:0] = 8'hEE;
      if (c == 9) begin req_in[2] = 1'b1; data_in[23:16] = 8'h33; end
      tick();
      if (c == 8) chk("stagger_req_early", req_out, 0);
    end
    chk("stagger_req_out", req_out, 1);
    chk("stagger_data", data_out, 24'h332211);
    chk("model_stagger_data", m_dout, 24'h332211);
    data_in = 24'hA5A5A5;
    tick();
    chk("req_hold_data", data_out, 24'h332211);
    chk("req_ack_in_low", ack_in, 0);
    ack_out = 1'b1; tick();
    chk("ack_in_all", ack_in, 3'b111);
    req_in = 3'b100; tick(); tick();
    chk("partial_release_req", req_out, 1);
    req_in = 3'b000; tick();
    chk("full_release_req", req_out, 0);
    chk("rtz_ack_in", ack_in, 3'b111);
    ack_out = 1'b0; tick();
    chk("done_ack_in", ack_in, 0);
    chk("done_cnt", cnt, 1);
    chk("model_done_cnt", m_cnt, 1);

    for (int t = 0; t < 4; t++) txn(W'($urandom));
    chk("wrap_cnt", cnt, 1);
    chk("wrap_err", err, 0);

    req_in = 3'b010; tick();
    req_in = 3'b000; tick();
    chk("withdraw_err", err, 1);
    tick(); tick(); tick();
    chk("withdraw_err_sticky", err, 1);
    chk("withdraw_no_req", req_out, 0);
    chk("model_withdraw_err", m_err, 1);

    req_in = '1; tick();
    chk("pre_rst_req", req_out, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", req_out, 0);
    chk("async_rst_ack", ack_in, 0);
    chk("async_rst_cnt", cnt, 0);
    chk("async_rst_err", err, 0);
    chk("async_rst_data", data_out, 0);
    req_in = '0;
    #1 rst_n = 1'b1;
    tick();

    // Randomised protocol traffic with rare violations and one reset.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!req_in[k] && !ack_in[k] && $urandom_range(2) == 0) begin
          req_in[k] = 1'b1;
          data_in[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        end else if (req_in[k] && ack_in[k] && $urandom_range(2) == 0) begin
          req_in[k] = 1'b0;
        end
        if ($urandom_range(999) == 0) req_in[k] = ~req_in[k];
        if ($urandom_range(3) == 0 && !req_in[k]) data_in[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      if (req_out && !ack_out && $urandom_range(1) == 0) ack_out = 1'b1;
      else if (!req_out && ack_out && $urandom_range(1) == 0) ack_out = 1'b0;
      if ($urandom_range(1499) == 0) ack_out = ~ack_out;
      if (i == 1500) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/join_n.md
JOIN_N -- requirements
Module: join_n

Interface
REQ-001 SHALL have parameter NUM_IN, default 2, number of joined input channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, per-channel payload width (legal 1..64).
REQ-003 SHALL have parameter CNT_W, default 8, transaction counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-005 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req_in_i  input  NUM_IN  four-phase request per input channel.
REQ-008 SHALL have port data_in_i  input  NUM_IN*DATA_W  payloads, channel k at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port ack_in_o  output  NUM_IN  four-phase acknowledge per input channel.
REQ-010 SHALL have port req_out_o  output  1  joined four-phase request.
REQ-011 SHALL have port data_out_o  output  NUM_IN*DATA_W  captured joined payload, same packing as input.
REQ-012 SHALL have port ack_out_i  input  1  downstream acknowledge.
REQ-013 SHALL have port err_o  output  1  sticky protocol-violation flag.
REQ-014 SHALL have port txn_cnt_o  output  CNT_W  completed-transaction count.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, ACK, RTZ; all outputs registered.
REQ-016 IDLE: req_out_o=0, ack_in_o=0; per-channel arrival flag arr[k] sets and data_in_i slice k captures on the first edge req_in_i[k]=1 is sampled; captured data not overwritten while arr[k]=1.
REQ-017 IDLE->REQ on the edge where every channel is arrived or arriving; req_out_o=1 from that edge (one-cycle latency from last request sampled).
REQ-018 REQ: hold req_out_o=1, data_out_o stable; on edge sampling ack_out_i=1 -> ACK, ack_in_o set to all ones.
REQ-019 ACK: on edge sampling all req_in_i=0 (C-element release rule) -> RTZ, req_out_o=0; partial release holds state.
REQ-020 RTZ: ack_in_o remains all ones; on edge sampling ack_out_i=0 -> IDLE, ack_in_o=0, all arr cleared, txn_cnt_o incremented by 1, modulo 2^CNT_W.
REQ-021 Simultaneous arrival of all channels on one edge SHALL behave as staggered arrival completing on that edge.
REQ-022 In IDLE, req_in_i[k] sampled 0 while arr[k]=1 (withdrawal) SHALL set err_o; arr[k] and data retained.
REQ-023 In REQ, any req_in_i bit sampled 0 SHALL set err_o; FSM continues per REQ-018.
REQ-024 In IDLE, ack_out_i sampled 1 SHALL set err_o.
REQ-025 err_o SHALL stay 1 until reset.
REQ-026 data_out_o SHALL be stable from IDLE->REQ edge until next IDLE->REQ edge.

Reset
REQ-027 rst_ni low SHALL immediately force: state IDLE, req_out_o=0, ack_in_o=0, arr=0, data_out_o=0, err_o=0, txn_cnt_o=0, regardless of clock or mid-transaction state.
REQ-028 After rst_ni rises, first state update SHALL occur on the next rising clk_i edge.

Structure
REQ-029 Shared package join_pkg SHALL hold the state enum (join_state_e) and legal parameter bounds.
REQ-030 Per-channel arrival flag plus payload register SHALL be sub-module join_slot, instantiated NUM_IN times by generate.

Verification
REQ-031 NUM_IN=3, DATA_W=8: reqs rise at cycles 2,5,9 with 0x11,0x22,0x33 -> req_out_o=1 at cycle 10, data_out_o=0x332211.
REQ-032 Full four-phase: ack_out_i=1 -> ack_in_o=3'b111 next cycle; all req_in low -> req_out_o=0; ack_out_i=0 -> ack_in_o=0, txn_cnt_o=1.
REQ-033 CNT_W=2, five complete transactions -> txn_cnt_o=1 (wrap).
REQ-034 Channel 1 withdraws req in IDLE before others arrive -> err_o=1 and stays 1; no req_out_o.
REQ-035 In ACK, release 2 of 3 reqs -> req_out_o stays 1; release third -> req_out_o=0 one edge later.
REQ-036 rst_ni pulsed low while in REQ -> req_out_o, ack_in_o, txn_cnt_o, err_o all 0 without a clock edge.
